// File: rtl/spram_access_ctrl_pkg.sv
// Shared types for the single-port RAM access controller: FSM state,
// arbitration pointer and the response skid-buffer bookkeeping.
package spram_access_ctrl_pkg;

  typedef enum logic {S_INIT, S_RUN} state_t;

  typedef enum logic {PRIO_WR, PRIO_RD} prio_t;

  localparam int RSP_BUF_DEPTH = 2;

  // Occupancy and pointers of the 2-entry response buffer.
  typedef struct packed {
    logic [1:0] cnt;
    logic       rd_ptr;
    logic       wr_ptr;
  } rsp_buf_t;

endpackage

// File: rtl/sync_spram.sv
// Single-port synchronous RAM with per-lane write strobes and a
// registered read port (read-first; data during a write is don't-care).
module sync_spram #(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 1024,
  parameter int BYTE_SIZE  = 8
) (
  input  logic                            clk,
  input  logic                            en,
  input  logic [DATA_WIDTH/BYTE_SIZE-1:0] strb,
  input  logic [$clog2(DATA_DEPTH)-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]           wdata,
  output logic [DATA_WIDTH-1:0]           rdata
);

  localparam int SW = DATA_WIDTH / BYTE_SIZE;

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < SW; i++) begin
        if (strb[i]) mem[addr][i*BYTE_SIZE +: BYTE_SIZE] <= wdata[i*BYTE_SIZE +: BYTE_SIZE];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/spram_access_ctrl.sv
// Zero-fills a single-port RAM after reset, then round-robins it between a
// write and a read channel; read data returns through a 2-entry skid buffer.
module spram_access_ctrl
  import spram_access_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 1024,
  parameter int BYTE_SIZE  = 8,
  parameter int INIT_EN    = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_valid_i,
  output logic                            wr_ready_o,
  input  logic [$clog2(DATA_DEPTH)-1:0]   wr_addr_i,
  input  logic [DATA_WIDTH/BYTE_SIZE-1:0] wr_strb_i,
  input  logic [DATA_WIDTH-1:0]           wr_data_i,
  input  logic                            rd_valid_i,
  output logic                            rd_ready_o,
  input  logic [$clog2(DATA_DEPTH)-1:0]   rd_addr_i,
  output logic                            rsp_valid_o,
  input  logic                            rsp_ready_i,
  output logic [DATA_WIDTH-1:0]           rsp_data_o,
  output logic                            init_done_o
);

  localparam int AW = $clog2(DATA_DEPTH);
  localparam int SW = DATA_WIDTH / BYTE_SIZE;

  // Handshake: a request transfers in the cycle its valid and the matching
  // ready are both high; ready is the combinational grant, so valid and
  // payload must stay stable until then. The response channel transfers on
  // rsp_valid_o & rsp_ready_i.

  state_t                state_q, state_d;
  prio_t                 prio_q;
  logic [AW-1:0]         init_addr_q;
  logic                  init_done_q;
  logic                  pend_q;
  rsp_buf_t              buf_q, buf_d;
  logic [DATA_WIDTH-1:0] buf_mem [RSP_BUF_DEPTH];

  logic                  credit, rd_req, wr_grant, rd_grant, contention;
  logic                  ram_en;
  logic [SW-1:0]         ram_strb;
  logic [AW-1:0]         ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;
  logic                  push, pop;

  // A read is only issued when its data is guaranteed a buffer slot.
  assign credit = (2'(pend_q) + buf_q.cnt) < 2'd2;
  assign rd_req = rd_valid_i & credit;

  always_comb begin
    state_d    = state_q;
    wr_grant   = 1'b0;
    rd_grant   = 1'b0;
    contention = 1'b0;
    ram_en     = 1'b0;
    ram_strb   = '0;
    ram_addr   = rd_addr_i;
    ram_wdata  = wr_data_i;
    case (state_q)
      S_INIT: begin
        ram_en    = 1'b1;
        ram_strb  = '1;
        ram_addr  = init_addr_q;
        ram_wdata = '0;
        if (init_addr_q == '1) state_d = S_RUN;
      end
      S_RUN: begin
        if (init_done_q) begin
          contention = wr_valid_i & rd_req;
          if (wr_valid_i && (!rd_req || prio_q == PRIO_WR)) wr_grant = 1'b1;
          else if (rd_req)                                   rd_grant = 1'b1;
        end
        ram_en = wr_grant | rd_grant;
        if (wr_grant) begin
          ram_strb = wr_strb_i;
          ram_addr = wr_addr_i;
        end
      end
    endcase
  end

  always_comb begin
    pop       = rsp_ready_i & (buf_q.cnt != 2'd0);
    push      = pend_q & ~((buf_q.cnt == 2'd0) & rsp_ready_i);
    buf_d     = buf_q;
    buf_d.cnt = buf_q.cnt + 2'(push) - 2'(pop);
    if (push) buf_d.wr_ptr = ~buf_q.wr_ptr;
    if (pop)  buf_d.rd_ptr = ~buf_q.rd_ptr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= (INIT_EN != 0) ? S_INIT : S_RUN;
      prio_q      <= PRIO_WR;
      init_addr_q <= '0;
      init_done_q <= 1'b0;
      pend_q      <= 1'b0;
      buf_q       <= '0;
    end else begin
      state_q     <= state_d;
      init_done_q <= (state_q == S_RUN);
      pend_q      <= rd_grant;
      buf_q       <= buf_d;
      if (state_q == S_INIT) init_addr_q <= init_addr_q + AW'(1);
      if (contention) prio_q <= wr_grant ? PRIO_RD : PRIO_WR;
    end
  end

  always_ff @(posedge clk) begin
    if (push) buf_mem[buf_q.wr_ptr] <= ram_rdata;
  end

  sync_spram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DATA_DEPTH(DATA_DEPTH),
    .BYTE_SIZE (BYTE_SIZE)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .strb (ram_strb),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  assign wr_ready_o  = wr_grant;
  assign rd_ready_o  = rd_grant;
  assign init_done_o = init_done_q;
  assign rsp_valid_o = pend_q | (buf_q.cnt != 2'd0);
  // Oldest data sits in the buffer; RAM output is only used when it is empty.
  assign rsp_data_o  = !rsp_valid_o            ? '0 :
                       (buf_q.cnt != 2'd0)     ? buf_mem[buf_q.rd_ptr] : ram_rdata;

endmodule

// File: tb/tb_spram_access_ctrl.sv
// Bench for spram_access_ctrl: directed scenarios plus random traffic checked
// against a word-array memory model and an in-order expected response queue.
module tb_spram_access_ctrl;

  localparam int DW = 32;
  localparam int DD = 16;
  localparam int BS = 8;
  localparam int AW = 4;
  localparam int SW = DW / BS;

  logic          clk;
  logic          rst_n;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [SW-1:0] wr_strb;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready;
  logic [AW-1:0] rd_addr;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          init_done;

  spram_access_ctrl #(
    .DATA_WIDTH(DW),
    .DATA_DEPTH(DD),
    .BYTE_SIZE (BS),
    .INIT_EN   (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid_i (wr_valid),
    .wr_ready_o (wr_ready),
    .wr_addr_i  (wr_addr),
    .wr_strb_i  (wr_strb),
    .wr_data_i  (wr_data),
    .rd_valid_i (rd_valid),
    .rd_ready_o (rd_ready),
    .rd_addr_i  (rd_addr),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_data_o (rsp_data),
    .init_done_o(init_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model and scoreboard
  logic [DW-1:0] model [DD];
  logic [DW-1:0] exp_q [$];
  bit            favor_rd;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [SW-1:0] s);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < SW; i++) if (s[i]) r[i*BS +: BS] = nw[i*BS +: BS];
    return r;
  endfunction

  // driver tasks
  task automatic cycle(input bit wv, input logic [AW-1:0] wa, input logic [SW-1:0] ws,
                       input logic [DW-1:0] wd, input bit rv, input logic [AW-1:0] ra,
                       input bit rr, output bit wg, output bit rg);
    int          outstanding;
    bit          rd_ok;
    logic [1:0]  exp_g;
    logic [DW-1:0] e;
    @(negedge clk);
    wr_valid = wv; wr_addr = wa; wr_strb = ws; wr_data = wd;
    rd_valid = rv; rd_addr = ra; rsp_ready = rr;
    #1;
    outstanding = exp_q.size();
    check("rsp_valid", DW'(rsp_valid), DW'(outstanding > 0));
    if (rsp_valid && rr && outstanding > 0) begin
      e = exp_q.pop_front();
      check("rsp_data", rsp_data, e);
    end
    rd_ok = rv && (outstanding < 2);
    if (wv && rd_ok) begin
      exp_g    = favor_rd ? 2'b01 : 2'b10;
      favor_rd = !favor_rd;
    end else begin
      exp_g = {wv, rd_ok};
    end
    check("grant", DW'({wr_ready, rd_ready}), DW'(exp_g));
    if (exp_g[1]) model[wa] = merge(model[wa], wd, ws);
    if (exp_g[0]) exp_q.push_back(model[ra]);
    wg = exp_g[1];
    rg = exp_g[0];
  endtask

  task automatic idle(input int n);
    bit wg, rg;
    for (int i = 0; i < n; i++) cycle(0, '0, '0, '0, 0, '0, 1, wg, rg);
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [SW-1:0] s, input logic [DW-1:0] d);
    bit wg, rg;
    int n = 0;
    do begin cycle(1, a, s, d, 0, '0, 1, wg, rg); n++; end while (!wg && n < 20);
  endtask

  task automatic read_word(input logic [AW-1:0] a);
    bit wg, rg;
    int n = 0;
    do begin cycle(0, '0, '0, '0, 1, a, 1, wg, rg); n++; end while (!rg && n < 20);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_flags", DW'({wr_ready, rd_ready, rsp_valid, init_done}), '0);
    check("reset_data", rsp_data, '0);
    rst_n = 1'b1;
    #1;
    check("post_reset_flags", DW'({wr_ready, rd_ready, rsp_valid, init_done}), '0);
    check("post_reset_data", rsp_data, '0);
    exp_q.delete();
    favor_rd = 1'b0;
    for (int i = 0; i < DD; i++) model[i] = '0;
  endtask

  // Counts cycles after reset release until init_done rises; requests are
  // offered during the fill and must not be granted.
  task automatic wait_fill(output int took);
    took = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      wr_valid = (k < 15); rd_valid = (k < 15);
      wr_addr = AW'(k); rd_addr = AW'(k); wr_strb = '1; wr_data = '1;
      #1;
      if (k < 15) check("init_ready", DW'({wr_ready, rd_ready}), '0);
      if (init_done) begin
        took = k;
        break;
      end
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
  endtask

  // stimulus
  initial begin
    int took, n, idx;
    bit wg, rg;
    bit wpend, rpend;
    logic [AW-1:0] wa, ra;
    logic [SW-1:0] ws;
    logic [DW-1:0] wd;
    logic [AW-1:0] bp_addr [3];

    rst_n = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1;
    wr_addr = '0; wr_strb = '0; wr_data = '0; rd_addr = '0;

    // Init fill latency
    do_reset();
    wait_fill(took);
    check("init_latency", DW'(took), DW'(17));

    // Garbage everywhere, so the refill below is observable
    for (int i = 0; i < DD; i++) write_word(AW'(i), '1, $urandom);
    read_word(AW'(5));
    read_word(AW'(12));
    idle(3);

    // Reset at fill address 7: fill restarts and takes a full pass again
    do_reset();
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      #1;
      check("mid_init_done", DW'(init_done), '0);
    end
    do_reset();
    wait_fill(took);
    check("refill_latency", DW'(took), DW'(17));
    for (int i = 0; i < DD; i++) read_word(AW'(i));
    idle(3);

    // Contention from reset priority: W, R, W, R, W, R
    for (int i = 0; i < 6; i++) cycle(1, AW'(8 + i), '1, 32'hC0DE_0000 + i, 1, AW'(i), 1, wg, rg);
    idle(3);

    // Streaming reads, one per cycle
    for (int i = 0; i < 8; i++) write_word(AW'(i), '1, 32'hA5A5_0000 + i);
    idx = 0; n = 0;
    while (idx < 8 && n < 30) begin
      cycle(0, '0, '0, '0, 1, AW'(idx), 1, wg, rg);
      n++;
      if (rg) idx++;
    end
    check("stream_cycles", DW'(n), DW'(8));
    idle(3);

    // Back-pressure: only two reads accepted, head holds word 3
    bp_addr[0] = 3; bp_addr[1] = 4; bp_addr[2] = 5;
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(0, '0, '0, '0, 1, bp_addr[idx], 0, wg, rg);
      if (rg) idx++;
    end
    check("bp_hold", rsp_data, model[3]);
    n = 0;
    while (idx < 3 && n < 20) begin
      cycle(0, '0, '0, '0, 1, bp_addr[idx], 1, wg, rg);
      n++;
      if (rg) idx++;
    end
    idle(4);

    // Byte strobes
    write_word(AW'(9), '1, 32'h1122_3344);
    write_word(AW'(9), 4'b0101, 32'hAABB_CCDD);
    read_word(AW'(9));
    idle(2);
    check("strobe_model", model[9], 32'h11BB_33DD);

    // Random traffic with random response back-pressure
    wpend = 0; rpend = 0; wa = '0; ra = '0; ws = '0; wd = '0;
    for (int i = 0; i < 600; i++) begin
      if (!wpend && $urandom_range(0, 2) == 0) begin
        wpend = 1; wa = AW'($urandom_range(0, DD - 1));
        ws = SW'($urandom_range(0, 15)); wd = $urandom;
      end
      if (!rpend && $urandom_range(0, 1) == 0) begin
        rpend = 1; ra = AW'($urandom_range(0, DD - 1));
      end
      cycle(wpend, wa, ws, wd, rpend, ra, $urandom_range(0, 3) != 0, wg, rg);
      if (wg) wpend = 0;
      if (rg) rpend = 0;
    end
    idle(6);

    // Mid-service reset drops buffered responses
    for (int i = 0; i < 4; i++) cycle(0, '0, '0, '0, 1, AW'(i), 0, wg, rg);
    do_reset();
    wait_fill(took);
    check("reset_in_service_latency", DW'(took), DW'(17));
    read_word(AW'(3));
    idle(3);

    // report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spram_access_ctrl.md
Name: spram_access_ctrl

Overview:
- Front-end controller that owns one single-port synchronous RAM and multiplexes it between a write channel and a read channel.
- After reset it sequences a zero-fill of the whole array.
- In service mode it grants at most one RAM access per cycle using round-robin arbitration.
- Read data returns through a valid/ready response channel with a 2-entry skid buffer, so downstream back-pressure never loses the RAM's 1-cycle read data.

Parameters:
- DATA_WIDTH, 32, word width in bits.
- DATA_DEPTH, 1024, number of words; power of two.
- BYTE_SIZE, 8, bits per write-strobe lane; DATA_WIDTH is a multiple of BYTE_SIZE.
- INIT_EN, 1, 1 = zero-fill the array after reset; 0 = enter service mode directly.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous to clk, active-low.
- wr_valid_i  in  1  write request valid.
- wr_ready_o  out  1  write granted this cycle.
- wr_addr_i  in  $clog2(DATA_DEPTH)  write word address.
- wr_strb_i  in  DATA_WIDTH/BYTE_SIZE  per-lane write enable.
- wr_data_i  in  DATA_WIDTH  write data.
- rd_valid_i  in  1  read request valid.
- rd_ready_o  out  1  read granted this cycle.
- rd_addr_i  in  $clog2(DATA_DEPTH)  read word address.
- rsp_valid_o  out  1  read response valid.
- rsp_ready_i  in  1  response consumer ready.
- rsp_data_o  out  DATA_WIDTH  read response data.
- init_done_o  out  1  high once service mode is entered.

Behaviour:
- Reset: synchronous, active-low. State, counters and pointer clear regardless of any in-flight work. Mid-init reset restarts the fill at address 0. Mid-service reset drops pending and buffered responses.
- Outputs during reset and the following cycle: wr_ready_o=0, rd_ready_o=0, rsp_valid_o=0, init_done_o=0, rsp_data_o=0.
- FSM states: S_INIT, S_RUN. Reset goes to S_INIT if INIT_EN=1, else S_RUN.
- S_INIT:
  - Each cycle writes all-zero data with all strobes high to init_addr, then init_addr increments.
  - All ready outputs are 0.
  - After the write to DATA_DEPTH-1 the FSM moves to S_RUN; init_done_o=1 from the next cycle.
  - Fill takes exactly DATA_DEPTH cycles.
- S_RUN read credit: credit = (pend + buf_cnt) < 2.
  - pend = a read was issued last cycle.
  - buf_cnt = skid occupancy, 0..2.
- S_RUN arbitration:
  - rd_req = rd_valid_i & credit.
  - If only one of wr_valid_i / rd_req is active, it is granted.
  - If both are active, the one selected by prio (reset value = WRITE) is granted, and prio then flips to the loser.
  - Grants are combinational: wr_ready_o / rd_ready_o assert only in the granted cycle. A requester must hold valid and payload until granted.
- RAM access: en = any grant or S_INIT. Write strobe = wr_strb_i on a write grant, 0 on a read grant.
  - Read granted in cycle t: RAM data is valid in t+1 (pend=1).
  - A write in t followed by a read of the same address in t+1 returns the new data.
  - Read-during-write data is never used.
- Response path:
  - rsp_valid_o = pend | (buf_cnt>0).
  - rsp_data_o = buffer head if buf_cnt>0, else RAM rdata.
  - In a pend cycle, the RAM data is pushed into the 2-entry buffer unless it is delivered directly (buf_cnt==0 & rsp_ready_i).
  - The buffer pops on rsp_valid_o & rsp_ready_i when it is non-empty.
  - Push and pop in the same cycle are allowed.
  - Responses return strictly in request order. The credit rule guarantees no overflow.
- Throughput: with rsp_ready_i=1 held, one read per cycle.
- Idle: no request leaves the RAM disabled (en=0).

Decomposition:
- Shared package: state enum {S_INIT, S_RUN}, arbitration-pointer enum {PRIO_WR, PRIO_RD}, typedef for the response-buffer entry.
- Sub-module: sync_spram, instantiated once as the storage array.
- The 2-entry response skid buffer stays inline.

Test Plan:
- Init fill: DATA_DEPTH=16, INIT_EN=1, preload garbage -> init_done_o rises exactly 17 cycles after rst_n deasserts; reads of addresses 0..15 return 0.
- Streaming read: write 0xA5A5_0000+i to addresses 0..7, then hold rd_valid_i with rsp_ready_i=1 -> one response per cycle, in order, first response one cycle after the first grant.
- Back-pressure: issue reads to addresses 3, 4, 5 with rsp_ready_i=0 -> rd_ready_o drops after 2 grants, rsp_data_o holds word 3. Releasing rsp_ready_i -> 3, 4, 5 delivered with no loss.
- Contention: wr_valid_i and rd_valid_i both held high for 6 cycles -> grants alternate W, R, W, R, W, R from reset priority.
- Byte strobe: write 0x11223344 full, then 0xAABBCCDD with strobe 4'b0101, then read -> 0x11BB33DD.
- Reset mid-init: assert rst_n=0 at fill address 7 -> fill restarts at 0, init_done_o stays 0 until a full DATA_DEPTH fill completes.
